// File: rtl/rtc_bus_responder_pkg.sv
// Shared constants for the V3023-style multiplexed A/D bus responder:
// default widths, FSM encodings, control bundle and the RTC register map.
package rtc_bus_responder_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int SYNC_N_MIN = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR_WR = 3'd1;
    localparam logic [2:0] ST_DATA_WR = 3'd2;
    localparam logic [2:0] ST_DATA_RD = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [3:0] REG_CONTROL = 4'h0;
    localparam logic [3:0] REG_SECONDS = 4'h1;
    localparam logic [3:0] REG_MINUTES = 4'h2;
    localparam logic [3:0] REG_HOURS   = 4'h3;
    localparam logic [3:0] REG_DATE0   = 4'h4;
    localparam logic [3:0] REG_DATE3   = 4'h7;

    typedef struct packed {
        logic cs;
        logic wr;
        logic rd;
        logic a_d;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_conflict(ctrl_t c);
        return !c.cs && !c.wr && !c.rd;
    endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// Pin-level bundle between the bus controller (master) and the
// RTC responder (slave); pin names follow the V3023 board netlist.
interface rtc_bus_responder_if
    import rtc_bus_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              CS;
    logic              WR;
    logic              RD;
    logic              A_D;
    logic [DATA_W-1:0] AD_in;
    logic [DATA_W-1:0] AD_out;
    logic              AD_oe;
    logic              wr_pulse;
    logic [ADDR_W-1:0] wr_addr;
    logic              proto_err;
    logic              addr_err;

    modport master (
        output CS,
        output WR,
        output RD,
        output A_D,
        output AD_in,
        input  AD_out,
        input  AD_oe,
        input  wr_pulse,
        input  wr_addr,
        input  proto_err,
        input  addr_err
    );

    modport slave (
        input  CS,
        input  WR,
        input  RD,
        input  A_D,
        input  AD_in,
        output AD_out,
        output AD_oe,
        output wr_pulse,
        output wr_addr,
        output proto_err,
        output addr_err
    );

endinterface

// File: rtl/rtc_bus_responder_sync.sv
// Multi-flop synchronizer plus one edge-detect stage per control line.
// Lines reset to the idle (high) level so release never looks like an edge.
module bus_sync_edge
    import rtc_bus_responder_pkg::*;
#(
    parameter int              WIDTH   = CTRL_W,
    parameter int              SYNC_N  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] lvl_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int N = (SYNC_N < SYNC_N_MIN) ? SYNC_N_MIN : SYNC_N;

    logic [WIDTH-1:0] sync_q [N];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= RST_VAL;
            end
            prev_q <= RST_VAL;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[N-1];
        end
    end

    assign lvl_o  = sync_q[N-1];
    assign rise_o = lvl_o & ~prev_q;
    assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Device end of the V3023 multiplexed A/D bus: pointer + byte register
// file, write capture on WR rise, registered read drive with turnaround.
module rtc_bus_responder
    import rtc_bus_responder_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AUTO_INC = 0,
    parameter int SYNC_N   = 2
) (
    input  logic                Clock_in,
    input  logic                Reset,
    rtc_bus_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    ctrl_t ctrl_raw;
    ctrl_t lvl;
    ctrl_t rise;
    ctrl_t fall;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              bad_q;
    logic              bad_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [DATA_W-1:0] ad_out_q;
    logic [DATA_W-1:0] ad_out_d;
    logic              ad_oe_q;
    logic              ad_oe_d;
    logic              wr_pulse_q;
    logic              wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              proto_q;
    logic              proto_d;
    logic              addr_err_q;
    logic              addr_err_d;
    logic              conflict;
    logic              conflict_q;
    logic              addr_oob;
    logic              unused_edges;

    assign ctrl_raw = '{
        cs:  bus.CS,
        wr:  bus.WR,
        rd:  bus.RD,
        a_d: bus.A_D
    };

    bus_sync_edge #(
        .WIDTH  (CTRL_W),
        .SYNC_N (SYNC_N),
        .RST_VAL('1)
    ) u_sync (
        .clk_i (Clock_in),
        .rst_ni(Reset),
        .d_i   (ctrl_raw),
        .lvl_o (lvl),
        .rise_o(rise),
        .fall_o(fall)
    );

    assign unused_edges = ^{fall, rise.a_d, rise.wr & rise.rd};

    assign conflict = is_conflict(lvl);
    assign addr_oob = (32'(bus.AD_in) >= 32'(DEPTH));

    // Conflict overrides every state; the phase type is latched at entry.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bad_d      = bad_q;
        mem_we     = 1'b0;
        ad_out_d   = ad_out_q;
        ad_oe_d    = 1'b0;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        addr_err_d = 1'b0;
        proto_d    = conflict & ~conflict_q;

        if (conflict) begin
            state_d = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!lvl.cs && !lvl.wr) begin
                        state_d = lvl.a_d ? ST_DATA_WR : ST_ADDR_WR;
                    end else if (!lvl.cs && !lvl.rd && lvl.a_d) begin
                        state_d  = ST_DATA_RD;
                        ad_oe_d  = 1'b1;
                        ad_out_d = bad_q ? '0 : mem_q[ptr_q];
                    end
                end
                ST_ADDR_WR: begin
                    if (rise.wr) begin
                        ptr_d      = bus.AD_in[ADDR_W-1:0];
                        bad_d      = addr_oob;
                        addr_err_d = addr_oob;
                        state_d    = ST_IDLE;
                    end else if (lvl.cs) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA_WR: begin
                    if (rise.wr) begin
                        if (!bad_q) begin
                            mem_we     = 1'b1;
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = ptr_q;
                        end
                        if (AUTO_INC != 0) begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                        state_d = ST_IDLE;
                    end else if (lvl.cs) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA_RD: begin
                    if (rise.rd || rise.cs || lvl.cs || lvl.rd) begin
                        if (AUTO_INC != 0) begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                        state_d = ST_HOLD;
                    end else begin
                        ad_oe_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            bad_q      <= 1'b0;
            ad_out_q   <= '0;
            ad_oe_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            proto_q    <= 1'b0;
            addr_err_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            bad_q      <= bad_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            proto_q    <= proto_d;
            addr_err_q <= addr_err_d;
            conflict_q <= conflict;
        end
    end

    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= bus.AD_in;
        end
    end

    assign bus.AD_out    = ad_out_q;
    assign bus.AD_oe     = ad_oe_q;
    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.proto_err = proto_q;
    assign bus.addr_err  = addr_err_q;

endmodule
